// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath (line buffer and conv_pe).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv_pkg;

    // Default pixel width, two's-complement signed.
    localparam int CONV_DATA_W = 16;

    // Line buffer sequencing states.
    typedef enum logic [1:0] {
        LB_IDLE = 2'd0,   // waiting for start of frame
        LB_FILL = 2'd1,   // lines 0 and 1 being stored, no output window yet
        LB_RUN  = 2'd2    // three rows available, emitting columns
    } lb_state_t;

endpackage

// File: rtl/conv_line_buffer_line_fifo.sv
// One stored image line: single-address memory, read-before-write, depth DEPTH x DATA_W.
// Latency: read is combinational from addr; the write lands on the clock edge.
// Backpressure: none, written only when the owner accepts a pixel.
//
// Ports:
//   clk    in   clock
//   addr   in   column address, shared by read and write
//   wr_en  in   write wr_dat at addr this cycle
//   wr_dat in   data to store
//   rd_dat out  value currently stored at addr (the value before this cycle's write)
module line_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 640,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [AW-1:0]     addr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_dat,
    output logic [DATA_W-1:0] rd_dat
);

    // Contents are don't-care after reset, so the array carries no reset.
    logic [DATA_W-1:0] r_mem [DEPTH];

    assign rd_dat = r_mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/conv_line_buffer.sv
// Raster pixel stream -> vertically aligned column triples (y-2, y-1, y) for conv_pe.
// Latency: 1 cycle from pixel accept to row*_out/pe_en.
// Backpressure: none; input is consumed whenever pix_va is high, outputs hold otherwise.
//
// Ports:
//   pclk      in   clock
//   rst       in   asynchronous active-low reset
//   pix_in    in   DATA_W  pixel, signed (passed bit-exact)
//   pix_va    in   pixel valid
//   pix_sof   in   start of frame, qualified by pix_va, marks pixel (0,0)
//   row0_out  out  pixel (y-2, x)
//   row1_out  out  pixel (y-1, x)
//   row2_out  out  pixel (y,   x)
//   pe_en     out  row*_out valid
//   frame_end out  pulse with the last pe_en of a frame
// Build option LB_ZERO_PAD_EN: top zero padding, rows not yet present read as 0 and
// every accepted pixel produces pe_en (FILL is skipped).
import conv_pkg::*;

module conv_line_buffer #(
    parameter int DATA_W = CONV_DATA_W,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_va,
    input  logic              pix_sof,
    output logic [DATA_W-1:0] row0_out,
    output logic [DATA_W-1:0] row1_out,
    output logic [DATA_W-1:0] row2_out,
    output logic              pe_en,
    output logic              frame_end
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

`ifdef LB_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    lb_state_t         r_state;
    lb_state_t         w_state_nxt;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [CW-1:0]     w_col_nxt;
    logic [RW-1:0]     w_row_nxt;

    logic              w_sof;
    logic              w_acc;
    logic [CW-1:0]     w_col;
    logic [RW-1:0]     w_row;
    logic              w_eol;
    logic              w_eof;
    logic [DATA_W-1:0] w_l0_rd;
    logic [DATA_W-1:0] w_l1_rd;
    logic [DATA_W-1:0] w_row0_dat;
    logic [DATA_W-1:0] w_row1_dat;
    logic              w_pe_en;

    // A sof pixel is always accepted and always sits at (0,0), aborting any frame in flight.
    assign w_sof = pix_va & pix_sof;
    assign w_acc = pix_va & ((r_state != LB_IDLE) | pix_sof);
    assign w_col = w_sof ? '0 : r_col;
    assign w_row = w_sof ? '0 : r_row;
    assign w_eol = (w_col == COL_LAST);
    assign w_eof = w_eol & (w_row == ROW_LAST);

    // Line 0 holds row y-1; its old value shifts into line 1, which then holds row y-2.
    line_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_line0 (
        .clk    (pclk),
        .addr   (w_col),
        .wr_en  (w_acc),
        .wr_dat (pix_in),
        .rd_dat (w_l0_rd)
    );

    line_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_line1 (
        .clk    (pclk),
        .addr   (w_col),
        .wr_en  (w_acc),
        .wr_dat (w_l0_rd),
        .rd_dat (w_l1_rd)
    );

    // With padding, stale memory from the previous frame must not leak into the top rows.
    assign w_row0_dat = (PAD_EN && (w_row < ROW_TWO)) ? '0 : w_l1_rd;
    assign w_row1_dat = (PAD_EN && (w_row == '0))    ? '0 : w_l0_rd;
    assign w_pe_en    = w_acc & (PAD_EN | (w_row >= ROW_TWO));

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_state <= LB_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        if (w_acc) begin
            if (w_eol) begin
                w_col_nxt = '0;
                w_row_nxt = w_eof ? '0 : (w_row + RW'(1));
            end else begin
                w_col_nxt = w_col + CW'(1);
                w_row_nxt = w_row;
            end
            if (w_eof) begin
                w_state_nxt = LB_IDLE;
            end else if (PAD_EN || (w_row_nxt >= ROW_TWO)) begin
                w_state_nxt = LB_RUN;
            end else begin
                w_state_nxt = LB_FILL;
            end
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            row0_out  <= '0;
            row1_out  <= '0;
            row2_out  <= '0;
            pe_en     <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            pe_en     <= w_pe_en;
            frame_end <= w_acc & w_eof;
            if (w_acc) begin
                row0_out <= w_row0_dat;
                row1_out <= w_row1_dat;
                row2_out <= pix_in;
            end
        end
    end

endmodule

// File: tb/tb_conv_line_buffer.sv
module tb_conv_line_buffer;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 4;

`ifdef LB_ZERO_PAD_EN
    localparam bit          PAD       = 1'b1;
    localparam int          FRAME_PE  = 16;
    localparam logic [47:0] FIRST_EXP = {16'd0, 16'd0, 16'd0};
`else
    localparam bit          PAD       = 1'b0;
    localparam int          FRAME_PE  = 8;
    localparam logic [47:0] FIRST_EXP = {16'd0, 16'd4, 16'd8};
`endif
    localparam logic [47:0] LAST_EXP = {16'd7, 16'd11, 16'd15};

    logic          pclk    = 1'b0;
    logic          rst     = 1'b0;
    logic [DW-1:0] pix_in  = '0;
    logic          pix_va  = 1'b0;
    logic          pix_sof = 1'b0;
    logic [DW-1:0] row0_out, row1_out, row2_out;
    logic          pe_en, frame_end;

    always #5 pclk = ~pclk;

    conv_line_buffer #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_va    (pix_va),
        .pix_sof   (pix_sof),
        .row0_out  (row0_out),
        .row1_out  (row1_out),
        .row2_out  (row2_out),
        .pe_en     (pe_en),
        .frame_end (frame_end)
    );

    typedef struct {
        logic [DW-1:0] r0;
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
        logic          fe;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    exp_t          last_exp;
    bit            have_last;
    int            n_vec = 0;
    int            n_bad = 0;
    int            pe_cnt, fe_cnt;
    logic [47:0]   cap_first, cap_last;
    bit            got_first;
    bit            saw_min, saw_max;

    // Frame image model: rows are kept as whole lines, outputs are read back from them.
    logic [DW-1:0] img [H][W];
    logic [DW-1:0] pat [W*H];
    int            m_r, m_c;
    bit            m_act;

    // Scoreboard consumer: every pe_en must match the oldest expected triple.
    always @(negedge pclk) begin
        if (rst) begin
            if (frame_end && !pe_en) begin
                n_vec++;
                n_bad++;
                $display("FAIL frame_end_alone: frame_end=1 with pe_en=0, required pe_en=1");
            end
            if (pe_en) begin
                pe_cnt++;
                if (frame_end) fe_cnt++;
                cap_last = {row0_out, row1_out, row2_out};
                if (!got_first) begin
                    cap_first = cap_last;
                    got_first = 1'b1;
                end
                if (row0_out == 16'h8000) saw_min = 1'b1;
                if (row0_out == 16'h7fff) saw_max = 1'b1;
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pe_en: got %0h/%0h/%0h fe=%0b, required no pe_en",
                             row0_out, row1_out, row2_out, frame_end);
                end else begin
                    mon_e = sb.pop_front();
                    if ({row0_out, row1_out, row2_out, frame_end} !==
                        {mon_e.r0, mon_e.r1, mon_e.r2, mon_e.fe}) begin
                        n_bad++;
                        $display("FAIL triple: got %0h/%0h/%0h fe=%0b, required %0h/%0h/%0h fe=%0b",
                                 row0_out, row1_out, row2_out, frame_end,
                                 mon_e.r0, mon_e.r1, mon_e.r2, mon_e.fe);
                    end
                    last_exp  = mon_e;
                    have_last = 1'b1;
                end
            end
        end
    end

    // Drive one cycle of input and record what the DUT must produce for it.
    task automatic drive(input logic [DW-1:0] p, input logic va, input logic sof);
        exp_t e;
        pix_in  = p;
        pix_va  = va;
        pix_sof = sof;
        if (va) begin
            if (sof) begin
                m_act = 1'b1;
                m_r   = 0;
                m_c   = 0;
            end
            if (m_act) begin
                img[m_r][m_c] = p;
                e.r2 = p;
                e.r1 = (m_r >= 1) ? img[m_r-1][m_c] : '0;
                e.r0 = (m_r >= 2) ? img[m_r-2][m_c] : '0;
                e.fe = (m_r == H-1) && (m_c == W-1);
                if (PAD || (m_r >= 2)) sb.push_back(e);
                if (m_c == W-1) begin
                    m_c = 0;
                    if (m_r == H-1) begin
                        m_r   = 0;
                        m_act = 1'b0;
                    end else begin
                        m_r++;
                    end
                end else begin
                    m_c++;
                end
            end
        end
        @(posedge pclk);
        #1;
    endtask

    task automatic clear_stats();
        pe_cnt    = 0;
        fe_cnt    = 0;
        got_first = 1'b0;
        saw_min   = 1'b0;
        saw_max   = 1'b0;
        for (int i = 0; i < W*H; i++) pat[i] = DW'(i);
    endtask

    // One full frame from pat[], optionally with an idle cycle after every pixel.
    task automatic run_frame(input bit gap);
        have_last = 1'b0;
        for (int i = 0; i < W*H; i++) begin
            drive(pat[i], 1'b1, i == 0);
            if (gap) begin
                drive(16'($urandom), 1'b0, 1'b0);
                if (have_last) begin
                    n_vec++;
                    if ({pe_en, row0_out, row1_out, row2_out} !==
                        {1'b0, last_exp.r0, last_exp.r1, last_exp.r2}) begin
                        n_bad++;
                        $display("FAIL gap_hold: got pe=%0b %0h/%0h/%0h, required pe=0 %0h/%0h/%0h",
                                 pe_en, row0_out, row1_out, row2_out,
                                 last_exp.r0, last_exp.r1, last_exp.r2);
                    end
                end
            end
        end
        repeat (3) drive('0, 1'b0, 1'b0);
    endtask

    task automatic check_frame_counts(input string name, input int exp_pe);
        n_vec++;
        if (pe_cnt !== exp_pe || fe_cnt !== 1 || sb.size() !== 0) begin
            n_bad++;
            $display("FAIL %s_counts: pe_en=%0d frame_end=%0d pending=%0d, required %0d/1/0",
                     name, pe_cnt, fe_cnt, sb.size(), exp_pe);
        end
    endtask

    task automatic test_reset();
        m_act = 1'b0;
        sb.delete();
        rst = 1'b0;
        repeat (10) begin
            pix_in  = 16'($urandom);
            pix_va  = 1'($urandom);
            pix_sof = 1'($urandom);
            @(posedge pclk);
            #1;
            n_vec++;
            if ({row0_out, row1_out, row2_out, pe_en, frame_end} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: got %0h/%0h/%0h pe=%0b fe=%0b, required all 0",
                         row0_out, row1_out, row2_out, pe_en, frame_end);
            end
        end
        rst = 1'b1;
        clear_stats();
        repeat (8) begin
            drive(16'($urandom), 1'($urandom), 1'b0);
            n_vec++;
            if (pe_en !== 1'b0) begin
                n_bad++;
                $display("FAIL no_sof_idle: pe_en=%0b, required 0", pe_en);
            end
        end
    endtask

    task automatic test_continuous();
        clear_stats();
        run_frame(1'b0);
        check_frame_counts("continuous", FRAME_PE);
        n_vec++;
        if (cap_first !== FIRST_EXP || cap_last !== LAST_EXP) begin
            n_bad++;
            $display("FAIL continuous_ends: first %h last %h, required %h / %h",
                     cap_first, cap_last, FIRST_EXP, LAST_EXP);
        end
    endtask

    task automatic test_gapped();
        clear_stats();
        run_frame(1'b1);
        check_frame_counts("gapped", FRAME_PE);
    endtask

    task automatic test_sof_abort();
        clear_stats();
        // Pixels (0,0)..(1,1), then sof lands where (1,2) would have been.
        for (int i = 0; i < 6; i++) drive(DW'(i), 1'b1, i == 0);
        run_frame(1'b0);
        check_frame_counts("sof_abort", FRAME_PE + (PAD ? 6 : 0));
    endtask

    task automatic test_extremes();
        clear_stats();
        pat[1] = 16'h8000;
        pat[2] = 16'h7fff;
        run_frame(1'b0);
        check_frame_counts("extremes", FRAME_PE);
        n_vec++;
        if (!(saw_min && saw_max)) begin
            n_bad++;
            $display("FAIL extremes_row0: saw -32768=%0b 32767=%0b on row0_out, required 1/1",
                     saw_min, saw_max);
        end
    endtask

`ifdef LB_ZERO_PAD_EN
    task automatic test_zero_pad();
        clear_stats();
        run_frame(1'b0);
        check_frame_counts("zero_pad", 16);
        n_vec++;
        if (cap_first !== 48'd0) begin
            n_bad++;
            $display("FAIL zero_pad_first: got %h, required 0", cap_first);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_continuous();
        test_gapped();
        test_sof_abort();
        test_extremes();
`ifdef LB_ZERO_PAD_EN
        test_zero_pad();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
